control_unit: RTL
=================

Name: control_unit

Overview:
Sequencer that drives the datapath control inputs: register write address, input-mux select and ALU op select. It accepts 4-bit instructions over a valid/ready handshake and expands each into a multi-cycle control sequence. It also handshakes external operand input and output-register results, and captures the ALU carry. It sits between the instruction source and data_path as the control end of that interface.

Parameters:
TIMEOUT_CYCLES, 0, max cycles to wait for operand data in WAIT_IN (0 = wait forever)
TO_W, 8, width of timeout counter; TIMEOUT_CYCLES must be < 2**TO_W

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
instr  in  4  {op[3:2], arg[1:0]}
instr_valid  in  1  instruction present
instr_ready  out  1  controller accepts instruction (IDLE only)
in_valid  in  1  operand on datapath data input valid
in_ready  out  1  controller consuming operand this cycle (WAIT_IN)
cout  in  1  registered carry from datapath
reg_addr  out  2  0=write A, 1=write B, 2=load O from A, 3=no write
s_reg  out  1  1=datapath input mux selects external input, 0=ALU result
s  out  1  ALU op: 0=add, 1=subtract
out_valid  out  1  O register holds a result
out_ready  in  1  downstream takes result
carry_flag  out  1  carry of last completed ALU instruction
busy  out  1  state != IDLE
timeout  out  1  one-cycle pulse on WAIT_IN abort

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE, reg_addr=3, s_reg=0, s=0, out_valid=0, carry_flag=0, timeout=0, instr latch=0, counter=0. Reset mid-sequence abandons the instruction; no write is issued in the reset cycle.
- Defaults in every state unless stated: reg_addr=3, s_reg=0, s=0, in_ready=0, instr_ready=0.
- Opcodes: 00 LDA, 01 LDB, 10 ALU (arg[0]=s, arg[1]=dest 0=A/1=B), 11 OUT when arg=00, otherwise NOP.
- IDLE: instr_ready=1. instr_valid=1 latches instr and moves to the decoded state. LDA/LDB go to WAIT_IN, ALU to EXEC, OUT to OUT_LOAD, NOP stays in IDLE.
- WAIT_IN: in_ready=1, s_reg=1. reg_addr=0 (LDA) or 1 (LDB) only in a cycle where in_valid=1, so the write happens at that edge; then go to IDLE.
  - With TIMEOUT_CYCLES>0, the counter increments each cycle without in_valid.
  - When the counter reaches TIMEOUT_CYCLES with in_valid=0: timeout pulses 1 cycle, no write, go to IDLE.
  - in_valid in the same cycle as the limit wins: load, no timeout.
- EXEC (1 cycle): reg_addr=dest, s_reg=0, s=arg[0]; the write happens at the end of the cycle. Next state CARRY.
- CARRY (1 cycle): s held at arg[0]; carry_flag<=cout. cout here reflects the op just executed. Next state IDLE.
- Per-instruction latency from accept: ALU=3 cycles back to IDLE, LDA/LDB=1+wait.
- OUT_LOAD (1 cycle): reg_addr=2. Next state OUT_HOLD with out_valid=1.
- OUT_HOLD: out_valid=1 and reg_addr=3, so O is never reloaded while held. out_ready=1 clears out_valid at the edge and returns to IDLE. Back-to-back OUT: the earliest next O load is 2 cycles after the handshake.
- out_valid never asserts outside OUT_HOLD. instr_ready and out_valid are never both 1.

Optional Feature:
CTRL_SKIP_CARRY_EN.
- Defined: op=11, arg=01 is SKC. If carry_flag=1, the next accepted instruction is discarded (acknowledged, no effect) and the skip flag clears; otherwise SKC is a NOP. The skip flag resets to 0.
- Undefined: 11/01 is a NOP and no skip logic exists.

Decomposition:
- Package ctrl_pkg:
  - opcode localparams (OP_LDA, OP_LDB, OP_ALU, OP_MISC);
  - reg_addr codes (RA_A, RA_B, RA_O, RA_NONE);
  - ALU select codes (ALU_ADD, ALU_SUB);
  - state encoding (IDLE, WAIT_IN, EXEC, CARRY, OUT_LOAD, OUT_HOLD).
- One sub-module, ctrl_decoder: combinational instr -> next-state/dest/alu-sel decode. The FSM, counter and flags stay in control_unit.

Test Plan:
- Reset asserted in WAIT_IN after LDA accepted -> next cycle IDLE, reg_addr=3, out_valid=0, carry_flag=0, busy=0.
- LDA with in_valid delayed 3 cycles -> in_ready high 4 cycles; reg_addr=0 with s_reg=1 only in the in_valid cycle; then IDLE.
- ALU instr 4'b1001 (sub, dest A) -> EXEC cycle: reg_addr=0, s_reg=0, s=1. CARRY: carry_flag takes cout=1. IDLE after 3 cycles.
- OUT then out_ready low 5 cycles -> reg_addr=2 for exactly 1 cycle, out_valid high 5 cycles with reg_addr=3 throughout, instr_ready=0. Clears on the out_ready cycle.
- TIMEOUT_CYCLES=4, LDB, in_valid never -> timeout pulse once after 4 waiting cycles, no reg_addr=1 issued. Repeat with in_valid exactly at the limit -> load, no timeout.
- CTRL_SKIP_CARRY_EN defined, carry_flag=1, SKC then LDA -> LDA acknowledged but no WAIT_IN; a following LDA executes normally.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared constants for the control_unit sequencer: opcodes, datapath
// register-write codes, ALU selects and FSM state encoding.
// Latency: n/a (constants only). Backpressure: n/a.
package ctrl_pkg;

  // Instruction opcodes, instr[3:2]
  localparam logic [1:0] OP_LDA  = 2'b00;
  localparam logic [1:0] OP_LDB  = 2'b01;
  localparam logic [1:0] OP_ALU  = 2'b10;
  localparam logic [1:0] OP_MISC = 2'b11;

  // Arguments of the MISC opcode, instr[1:0]
  localparam logic [1:0] ARG_OUT = 2'b00;
  localparam logic [1:0] ARG_SKC = 2'b01;

  // Datapath register-write address codes
  localparam logic [1:0] RA_A    = 2'd0;
  localparam logic [1:0] RA_B    = 2'd1;
  localparam logic [1:0] RA_O    = 2'd2;
  localparam logic [1:0] RA_NONE = 2'd3;

  // ALU operation select
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  // FSM state encoding
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WAIT_IN  = 3'd1;
  localparam logic [2:0] EXEC     = 3'd2;
  localparam logic [2:0] CARRY    = 3'd3;
  localparam logic [2:0] OUT_LOAD = 3'd4;
  localparam logic [2:0] OUT_HOLD = 3'd5;

endpackage

// File: rtl/ctrl_decoder.sv
// Purpose: decode a 4-bit instruction into the FSM state it starts in,
//   its datapath write destination and its ALU select.
// Latency: purely combinational. Backpressure: none (pure function of i_instr).
// Ports:
//   i_instr      {op[1:0], arg[1:0]}
//   o_next_state state entered when the instruction is accepted (IDLE = no-op)
//   o_dest       register-write code used by the instruction
//   o_alu_sel    ALU operation (ALU instructions only, else add)
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [3:0] i_instr,
  output logic [2:0] o_next_state,
  output logic [1:0] o_dest,
  output logic       o_alu_sel
);

  always_comb begin
    o_next_state = IDLE;
    o_dest       = RA_NONE;
    o_alu_sel    = ALU_ADD;
    case (i_instr[3:2])
      OP_LDA: begin
        o_next_state = WAIT_IN;
        o_dest       = RA_A;
      end
      OP_LDB: begin
        o_next_state = WAIT_IN;
        o_dest       = RA_B;
      end
      OP_ALU: begin
        o_next_state = EXEC;
        o_dest       = i_instr[1] ? RA_B : RA_A;
        o_alu_sel    = i_instr[0];
      end
      default: begin
        // MISC: only OUT starts a sequence; every other argument is a no-op here
        if (i_instr[1:0] == ARG_OUT) begin
          o_next_state = OUT_LOAD;
          o_dest       = RA_O;
        end
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Purpose: sequencer expanding 4-bit instructions into datapath control
//   (reg_addr, s_reg, s), handshaking operands and results, capturing carry.
// Latency: ALU 3 cycles accept->IDLE, LDA/LDB 1 + operand wait, OUT 2 + result wait.
// Backpressure: instr_ready only in IDLE; stalls in WAIT_IN on in_valid, OUT_HOLD on out_ready.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   instr/instr_valid/instr_ready   instruction handshake
//   in_valid/in_ready        external operand handshake
//   cout                     registered datapath carry
//   reg_addr, s_reg, s       datapath control outputs
//   out_valid/out_ready      O-register result handshake
//   carry_flag, busy, timeout status
// Optional: define CTRL_SKIP_CARRY_EN to add SKC (op 11, arg 01): skip the
//   next accepted instruction when carry_flag is set.
module control_unit
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int TO_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] instr,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       cout,
  output logic [1:0] reg_addr,
  output logic       s_reg,
  output logic       s,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       carry_flag,
  output logic       busy,
  output logic       timeout
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  logic [2:0]      r_state;
  logic [1:0]      r_dest;
  logic            r_alu_s;
  logic [TO_W-1:0] r_cnt;
  logic            r_out_valid;
  logic            r_carry;
  logic            r_timeout;

  logic [2:0]      w_next_state;
  logic [1:0]      w_dest;
  logic            w_alu_sel;
  logic            w_discard;
  logic            w_at_limit;

  ctrl_decoder u_dec (
    .i_instr      (instr),
    .o_next_state (w_next_state),
    .o_dest       (w_dest),
    .o_alu_sel    (w_alu_sel)
  );

  assign w_at_limit = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LIMIT);

`ifdef CTRL_SKIP_CARRY_EN
  logic r_skip;
  logic w_is_skc;

  assign w_is_skc  = (instr == {OP_MISC, ARG_SKC});
  assign w_discard = r_skip;

  // Any accepted instruction consumes a pending skip; SKC arms it only on carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_skip <= 1'b0;
    end else if (r_state == IDLE && instr_valid) begin
      r_skip <= r_skip ? 1'b0 : (w_is_skc && r_carry);
    end
  end
`else
  assign w_discard = 1'b0;
`endif

  // Control outputs are forced idle while rst is high so no write is issued
  // in the reset cycle, whatever state is being abandoned.
  always_comb begin
    reg_addr    = RA_NONE;
    s_reg       = 1'b0;
    s           = ALU_ADD;
    in_ready    = 1'b0;
    instr_ready = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE:     instr_ready = 1'b1;
        WAIT_IN: begin
          in_ready = 1'b1;
          s_reg    = 1'b1;
          if (in_valid) reg_addr = r_dest;
        end
        EXEC: begin
          reg_addr = r_dest;
          s        = r_alu_s;
        end
        CARRY:    s        = r_alu_s;
        OUT_LOAD: reg_addr = RA_O;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_dest      <= 2'd0;
      r_alu_s     <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_carry     <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (instr_valid && !w_discard) begin
            r_state <= w_next_state;
            r_dest  <= w_dest;
            r_alu_s <= w_alu_sel;
            r_cnt   <= '0;
          end
        end
        WAIT_IN: begin
          if (in_valid) begin
            r_state <= IDLE;
          end else if (w_at_limit) begin
            r_timeout <= 1'b1;
            r_state   <= IDLE;
          end else if (TIMEOUT_CYCLES != 0) begin
            r_cnt <= r_cnt + TO_W'(1);
          end
        end
        EXEC:  r_state <= CARRY;
        CARRY: begin
          r_carry <= cout;
          r_state <= IDLE;
        end
        OUT_LOAD: begin
          r_out_valid <= 1'b1;
          r_state     <= OUT_HOLD;
        end
        OUT_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign carry_flag = r_carry;
  assign timeout    = r_timeout;
  assign busy       = (r_state != IDLE);

endmodule
